// File: rtl/counter_mod_k_cascade.sv
// Cascade of NUM_STAGES runtime-modulus counters (stage 0 least significant) with enable,
// direction, synchronous clear and one-cycle rollover flags. Optional one-shot stop: COUNTER_CASCADE_ONESHOT_EN.
module counter_mod_k_cascade #(
    parameter int unsigned N          = 8,
    parameter int unsigned NUM_STAGES = 2
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_en,
    input  logic                    i_clear,
    input  logic                    i_down,
    input  logic [NUM_STAGES*N-1:0] i_k,
`ifdef COUNTER_CASCADE_ONESHOT_EN
    input  logic                    i_one_shot,
    output logic                    o_done,
`endif
    output logic [NUM_STAGES*N-1:0] o_count,
    output logic [NUM_STAGES-1:0]   o_roll_over
);

    logic [NUM_STAGES*N-1:0] count_q, count_d;
    logic [NUM_STAGES-1:0]   roll_q, roll_d;
    logic [NUM_STAGES-1:0]   wrap, adv;
    logic                    hold;
    logic                    top_wrap;

    always_comb begin : next_state_comb
        logic         carry;
        logic [N-1:0] cur;
        logic [N-1:0] term;
        count_d = count_q;
        roll_d  = '0;
        wrap    = '0;
        adv     = '0;
        cur     = '0;
        term    = '0;
        carry   = i_en & ~hold;
        for (int s = 0; s < NUM_STAGES; s++) begin
            cur  = count_q[s*N +: N];
            // Modulus 0 means 2^N, which the wrapping subtraction yields as all ones.
            term = i_k[s*N +: N] - N'(1);
            wrap[s] = i_down ? (cur == '0) : (cur >= term);
            adv[s]  = carry;
            carry   = carry & wrap[s];
            if (i_clear) begin
                count_d[s*N +: N] = '0;
            end else if (adv[s]) begin
                if (!i_down) begin
                    if (wrap[s]) begin
                        count_d[s*N +: N] = '0;
                        roll_d[s]         = 1'b1;
                    end else begin
                        count_d[s*N +: N] = cur + N'(1);
                    end
                end else if (cur == '0) begin
                    count_d[s*N +: N] = term;
                    roll_d[s]         = 1'b1;
                end else if (cur > term) begin
                    count_d[s*N +: N] = term;
                end else begin
                    count_d[s*N +: N] = cur - N'(1);
                end
            end
        end
    end

    assign top_wrap = adv[NUM_STAGES-1] & wrap[NUM_STAGES-1];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count_q <= '0;
            roll_q  <= '0;
        end else begin
            count_q <= count_d;
            roll_q  <= roll_d;
        end
    end

`ifdef COUNTER_CASCADE_ONESHOT_EN
    logic done_q, done_d;

    always_comb begin
        done_d = done_q;
        if (i_clear) begin
            done_d = 1'b0;
        end else if (i_one_shot && top_wrap) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    assign hold   = done_q;
    assign o_done = done_q;
`else
    assign hold = 1'b0;
    logic unused_top_wrap;
    assign unused_top_wrap = top_wrap;
`endif

    assign o_count     = count_q;
    assign o_roll_over = roll_q;

endmodule

// File: doc/counter_mod_k_cascade.md
Name: counter_mod_k_cascade

Overview:
Parametrised successor of the single modulo-k rollover counter. It chains NUM_STAGES modulo counters, each with its own runtime modulus, into one synchronous cascade, like a prescaler or timebase divider. Adds enable, up/down direction, synchronous clear, and registered per-stage rollover flags. Used as a timebase generator, for example for a clock divider or for a seconds/minutes-style tick tree.

Parameters:
- N, 8, width of each stage's count and modulus.
- NUM_STAGES, 2, number of cascaded stages (>=1); stage 0 is least significant.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_en  in  1  count enable for stage 0.
- i_clear  in  1  synchronous clear of all stages.
- i_down  in  1  direction: 0 = up, 1 = down (all stages).
- i_k  in  NUM_STAGES*N  packed moduli; stage s uses bits [s*N +: N].
- o_count  out  NUM_STAGES*N  packed registered stage counts; stage s at [s*N +: N].
- o_roll_over  out  NUM_STAGES  bit s is high for exactly the cycle after stage s wrapped.

Behaviour:
- One clock, i_clk. Reset is asynchronous and active-low on i_reset_n.
- While i_reset_n=0: all o_count=0 and all o_roll_over=0, immediately and without a clock edge. Reset mid-count discards all state.
- Priority per edge: reset, then i_clear, then count.
- i_clear=1: all counts go to 0 and all o_roll_over go to 0 at that edge, regardless of i_en.
- Effective modulus M_s = i_k slice; M_s=0 means modulus 2^N. Terminal value T_s = M_s-1 in N-bit arithmetic, so k=0 gives T=all ones.
- Advance condition:
  - adv_0 = i_en.
  - adv_s = adv_(s-1) AND stage s-1 at its wrap point in the current cycle.
  - The cascade is fully synchronous: all stages update on the same edge, with no ripple delay.
- Wrap point:
  - Up mode: count >= T_s.
  - Down mode: count == 0.
- Up mode, stage advancing:
  - count >= T_s: count becomes 0; roll_over_s becomes 1.
  - Otherwise: count+1; roll_over_s becomes 0.
- Down mode, stage advancing:
  - count == 0: count becomes T_s; roll_over_s becomes 1.
  - count > T_s (out of range after a k change): count becomes T_s; roll_over_s becomes 0.
  - Otherwise: count-1; roll_over_s becomes 0.
- Stage not advancing: count holds; roll_over_s becomes 0. A flag is never held for more than one cycle.
- k=1: count stays 0 and the stage rolls over on every advance.
- i_k may change at any time and takes effect at the next edge. In up mode, an out-of-range count wraps to 0 with rollover at its next advance.
- Changing i_down mid-count takes effect at the next edge from the current count.
- Top stage wrap sets o_roll_over[NUM_STAGES-1]; the cascade then continues from all-wrapped values.
- Latency: count change visible 1 cycle after the enabling edge; rollover flag high in the same cycle as the wrapped count.

Optional Feature:
Macro: COUNTER_CASCADE_ONESHOT_EN.
- Defined:
  - Adds input i_one_shot (1 bit) and output o_done (1 bit, reset 0).
  - With i_one_shot=1, the top-stage wrap sets o_done=1 at the same edge as its rollover flag.
  - While o_done=1, all stages hold regardless of i_en, and o_roll_over stays 0 after its single pulse.
  - i_clear or reset clears o_done.
  - With i_one_shot=0, behaviour is identical to free-running.
- Not defined: no extra ports; the cascade is always free-running.

Test Plan:
- Setup for all scenarios: N=4, NUM_STAGES=2.
1. Reset low then release; k0=3, k1=2; up mode; i_en=1 for 12 edges -> count0 0,1,2,0,1,2,... and count1 increments on each stage-0 wrap. roll_over[0] high after edges 3, 6, 9, 12; roll_over[1] high after edges 6 and 12 only.
2. k0=0 (2^N), up mode, 16 enabled edges -> count0 runs 0..15 then 0; roll_over[0] high only after edge 16.
3. Down mode, k0=3, k1=2, from reset -> first edge gives count0=2, count1=1, with roll_over[0]=1 and roll_over[1]=1. Second edge gives count0=1, count1=1, with no flags.
4. Up mode, count0=5 with k0=8, then change k0 to 4 -> next enabled edge gives count0=0 and roll_over[0]=1.
5. Toggle i_en and drive i_clear together with i_en=1 mid-count -> counts hold when i_en=0; clear wins and gives counts 0 and flags 0. Async reset asserted between edges zeroes outputs immediately.
6. With COUNTER_CASCADE_ONESHOT_EN, i_one_shot=1, k0=3, k1=2 -> o_done=1 after edge 6. Counts stay 0 and the flags stay low for 10 more enabled edges; i_clear restarts counting.
